// File: rtl/mult_div_pkg.sv
// Shared funct codes and field widths for the EX-stage multiply/divide unit.
// No logic beyond a start-code decode helper.
// No flow control.
package mult_div_pkg;

    localparam int FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
    localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

    function automatic logic is_start(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Combinational, zero latency.
// No flow control.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,      // partial remainder already shifted left by one
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] diff;

    always_comb begin
        diff  = rem_i - {1'b0, divisor_i};
        q_o   = (rem_i >= {1'b0, divisor_i});
        rem_o = q_o ? diff[WIDTH-1:0] : rem_i[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO writes.
// Start -> WIDTH busy cycles -> DONE; HI/LO visible WIDTH+2 cycles after start. MTHI/MTLO: 1 cycle.
// stall_req held while accepting and while busy; dropped in DONE so the pipeline retires the op.
module mult_div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   operand_1,
    input  logic [WIDTH-1:0]   operand_2,
    output logic               stall_req,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;   // negate product / quotient
    logic               neg_rem_q, neg_rem_d;   // dividend was negative
    logic [WIDTH-1:0]   a_q, a_d;               // multiplier, or dividend shifting into quotient
    logic [2*WIDTH-1:0] b_q, b_d;               // multiplicand shifting left, or divisor in low half
    logic [2*WIDTH-1:0] acc_q, acc_d;           // product, or remainder in low half
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               start_sgn, a_neg, b_neg, start_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     ({acc_q[WIDTH-1:0], a_q[WIDTH-1]}),
        .divisor_i (b_q[WIDTH-1:0]),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    assign hi = hi_q;
    assign lo = lo_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stall_req = 1'b0;

        start_sgn = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
        start_div = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
        a_neg     = start_sgn & operand_1[WIDTH-1];
        b_neg     = start_sgn & operand_2[WIDTH-1];
        a_mag     = a_neg ? -operand_1 : operand_1;
        b_mag     = b_neg ? -operand_2 : operand_2;
        prod      = neg_res_q ? -acc_q : acc_q;

        case (state_q)
            IDLE: begin
                if (en && is_start(funct)) begin
                    stall_req = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = '0;
                    is_div_d  = start_div;
                    // A zero divisor leaves the quotient all ones, so it must not be negated.
                    neg_res_d = (a_neg ^ b_neg) & ~(start_div && (operand_2 == '0));
                    neg_rem_d = a_neg;
                    a_d       = a_mag;
                    b_d       = {{WIDTH{1'b0}}, b_mag};
                    acc_d     = '0;
                end else if (en && (funct == FUNCT_MTHI)) begin
                    hi_d = operand_1;
                end else if (en && (funct == FUNCT_MTLO)) begin
                    lo_d = operand_1;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (is_div_q) begin
                    acc_d = {{WIDTH{1'b0}}, step_rem};
                    a_d   = {a_q[WIDTH-2:0], step_q};
                end else begin
                    if (a_q[0]) acc_d = acc_q + b_q;
                    b_d = b_q << 1;
                    a_d = a_q >> 1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                // Divide by zero leaves |dividend| as remainder; the sign fixup restores operand_1.
                if (is_div_q) begin
                    lo_d = neg_res_q ? -a_q : a_q;
                    hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end else begin
                    {hi_d, lo_d} = prod;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d   = IDLE;
            hi_d      = hi_q;
            lo_d      = lo_q;
            stall_req = (state_q == BUSY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Randomized and directed bench for mult_div against an arithmetic HI/LO model.
// Holds each instruction in EX until stall_req is sampled low, like the real pipeline.
module tb_mult_div;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         flush = 1'b0;
    logic [5:0]   funct = 6'h00;
    logic [W-1:0] operand_1 = '0;
    logic [W-1:0] operand_2 = '0;
    logic         stall_req;
    logic [W-1:0] hi, lo;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int n_total = 0;
    int n_pass  = 0;

    mult_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .funct     (funct),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit is_start_code(input logic [5:0] f);
        return (f >= 6'h18) && (f <= 6'h1B);
    endfunction

    // Architectural result of one instruction, from plain integer arithmetic.
    task automatic model_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint     sp;
        logic [63:0] up;
        int         sa, sb;
        case (f)
            6'h18: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = sp;
            end
            6'h19: begin
                up = {32'b0, a} * {32'b0, b};
                {m_hi, m_lo} = up;
            end
            6'h1A: begin
                if (b == 0) begin
                    m_lo = '1; m_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = '0;
                end else begin
                    sa = a; sb = b;
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            6'h1B: begin
                if (b == 0) begin
                    m_lo = '1; m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            6'h11: m_hi = a;
            6'h13: m_lo = a;
            default: ;
        endcase
    endtask

    // Entered and left at a negedge; the instruction retires on the edge after stall_req is low.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int stalls, output bit retired);
        en = 1'b1; funct = f; operand_1 = a; operand_2 = b;
        stalls = 0; retired = 1'b0;
        for (int c = 0; c < 200 && !retired; c++) begin
            #1;
            if (stall_req) stalls++;
            else retired = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        en = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int stalls;
        bit retired;
        issue(f, a, b, stalls, retired);
        model_op(f, a, b);
        check_eq({tag, ".retire"}, 64'(retired), 64'd1);
        check_eq({tag, ".stalls"}, 64'(stalls), is_start_code(f) ? 64'(W + 1) : 64'd0);
        check_eq({tag, ".hi"}, 64'(hi), 64'(m_hi));
        check_eq({tag, ".lo"}, 64'(lo), 64'(m_lo));
    endtask

    logic [5:0]   op_tab [9]  = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h10, 6'h12, 6'h20};
    logic [W-1:0] edge_tab [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7};

    function automatic logic [W-1:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return edge_tab[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset.hi", 64'(hi), 64'd0);
        check_eq("reset.lo", 64'(lo), 64'd0);
        check_eq("reset.stall", 64'(stall_req), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mult_neg", 6'h18, 32'hFFFF_FFFE, 32'h0000_0003);
        run_op("divu_100_7", 6'h1B, 32'd100, 32'd7);
        run_op("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_by0", 6'h1B, 32'd5, 32'd0);
        run_op("div_by0_neg", 6'h1A, 32'hFFFF_FFF0, 32'd0);
        run_op("mtlo", 6'h13, 32'h1234, 32'h0);
        run_op("mthi", 6'h11, 32'h5678, 32'h0);

        // Flush at BUSY cycle 10 aborts the multiply without touching HI/LO.
        en = 1'b1; funct = 6'h19; operand_1 = 32'hDEAD_BEEF; operand_2 = 32'h1357_9BDF;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check_eq("flush.busy_stall", 64'(stall_req), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; en = 1'b0;
        #1;
        check_eq("flush.stall", 64'(stall_req), 64'd0);
        check_eq("flush.hi", 64'(hi), 64'(m_hi));
        check_eq("flush.lo", 64'(lo), 64'(m_lo));
        repeat (40) @(negedge clk);
        check_eq("flush.hi_later", 64'(hi), 64'(m_hi));
        check_eq("flush.lo_later", 64'(lo), 64'(m_lo));
        run_op("multu_3_4", 6'h19, 32'd3, 32'd4);

        // Asynchronous reset mid-operation, between clock edges.
        run_op("mthi_pre_rst", 6'h11, 32'hCAFE_0001, 32'h0);
        en = 1'b1; funct = 6'h18; operand_1 = 32'h0001_0003; operand_2 = 32'hFFF0_0005;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2;
        rst = 1'b1; en = 1'b0;
        #1;
        check_eq("arst.hi", 64'(hi), 64'd0);
        check_eq("arst.lo", 64'(lo), 64'd0);
        check_eq("arst.stall", 64'(stall_req), 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("post_rst_divu", 6'h1B, 32'd100, 32'd7);

        for (int i = 0; i < 60; i++) begin
            run_op($sformatf("rnd%0d", i), op_tab[$urandom_range(0, 8)], pick_operand(), pick_operand());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
